// File: rtl/flop_enable_reset.sv
// Enabled, synchronously reset register, built from a 2:1 mux that recirculates q
// and a plain reset flop. The companion modules are usable on their own.

// Plain register with synchronous active-high clear.
module flop_reset #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset takes priority; otherwise capture d on every rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// Purely combinational 2:1 select, bit for bit, no storage.
module mux2 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  // Select d1 when s is high, d0 otherwise.
  always_comb begin
    y = d0;
    if (s) begin
      y = d1;
    end
  end

endmodule

// Register that loads d only while enable is high; reset wins over enable.
module flop_enable_reset #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] d_next;

  // Hold is implemented by feeding q back when enable is low.
  mux2 #(
    .WIDTH(WIDTH)
  ) u_sel (
    .d0(q),
    .d1(d),
    .s (enable),
    .y (d_next)
  );

  flop_reset #(
    .WIDTH(WIDTH)
  ) u_reg (
    .clock(clock),
    .reset(reset),
    .d    (d_next),
    .q    (q)
  );

endmodule

// File: tb/tb_flop_enable_reset.sv
// Self-checking bench for flop_enable_reset, flop_reset and mux2 at WIDTH 1, 16 and 32.
module tb_flop_enable_reset;

  logic        clk = 1'b0;
  logic        rst, en, s;
  logic [31:0] d, d0, d1;

  logic [0:0]  fer_q1,  fr_q1,  y1;
  logic [15:0] fer_q16, fr_q16, y16;
  logic [31:0] fer_q32, fr_q32, y32;

  // Reference state, kept at full 32-bit width and truncated per instance.
  logic [31:0] m_fer, m_fr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flop_enable_reset #(.WIDTH(1)) u_fer1 (
    .clock(clk), .reset(rst), .enable(en), .d(d[0:0]), .q(fer_q1));
  flop_enable_reset u_fer16 (
    .clock(clk), .reset(rst), .enable(en), .d(d[15:0]), .q(fer_q16));
  flop_enable_reset #(.WIDTH(32)) u_fer32 (
    .clock(clk), .reset(rst), .enable(en), .d(d), .q(fer_q32));

  flop_reset #(.WIDTH(1)) u_fr1 (.clock(clk), .reset(rst), .d(d[0:0]), .q(fr_q1));
  flop_reset u_fr16 (.clock(clk), .reset(rst), .d(d[15:0]), .q(fr_q16));
  flop_reset #(.WIDTH(32)) u_fr32 (.clock(clk), .reset(rst), .d(d), .q(fr_q32));

  mux2 #(.WIDTH(1)) u_mx1 (.d0(d0[0:0]), .d1(d1[0:0]), .s(s), .y(y1));
  mux2 u_mx16 (.d0(d0[15:0]), .d1(d1[15:0]), .s(s), .y(y16));
  mux2 #(.WIDTH(32)) u_mx32 (.d0(d0), .d1(d1), .s(s), .y(y32));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_flops(input string tag);
    check({tag, " fer1"},  {31'b0, fer_q1},  {31'b0, m_fer[0]});
    check({tag, " fer16"}, {16'b0, fer_q16}, {16'b0, m_fer[15:0]});
    check({tag, " fer32"}, fer_q32,          m_fer);
    check({tag, " fr1"},   {31'b0, fr_q1},   {31'b0, m_fr[0]});
    check({tag, " fr16"},  {16'b0, fr_q16},  {16'b0, m_fr[15:0]});
    check({tag, " fr32"},  fr_q32,           m_fr);
  endtask

  // Drive one edge's inputs, let the edge pass, then advance the model and compare.
  task automatic step(input string tag, input logic r, input logic e, input logic [31:0] dv);
    rst = r;
    en  = e;
    d   = dv;
    @(posedge clk);
    #1;
    if (r) begin
      m_fer = '0;
      m_fr  = '0;
    end else begin
      if (e) m_fer = dv;
      m_fr = dv;
    end
    check_flops(tag);
  endtask

  task automatic check_mux(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sel);
    logic [31:0] exp;
    d0 = a;
    d1 = b;
    s  = sel;
    #1;
    exp = sel ? b : a;
    check({tag, " y1"},  {31'b0, y1},  {31'b0, exp[0]});
    check({tag, " y16"}, {16'b0, y16}, {16'b0, exp[15:0]});
    check({tag, " y32"}, y32,          exp);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; s = 1'b0;
    d = '0; d0 = '0; d1 = '0;
    m_fer = '0; m_fr = '0;
    @(negedge clk);

    // Reset wins over an enabled load.
    step("reset_beef", 1'b1, 1'b1, 32'h0000_BEEF);

    // Load then hold for three edges.
    step("load_1234", 1'b0, 1'b1, 32'h0000_1234);
    for (int i = 0; i < 3; i++) step("hold_ffff", 1'b0, 1'b0, 32'h0000_FFFF);

    // Wiggle inputs between edges: the registers must not move.
    for (int i = 0; i < 4; i++) begin
      en = 1'(i);
      d  = $urandom;
      #1;
      check("midcycle fer32", fer_q32, m_fer);
      check("midcycle fer16", {16'b0, fer_q16}, {16'b0, m_fer[15:0]});
    end
    step("reset_5555", 1'b1, 1'b1, 32'h0000_5555);

    // flop_reset follows d with a one-cycle lag, reset on the fourth edge.
    step("seq_0001", 1'b0, 1'b1, 32'h0000_0001);
    step("seq_8000", 1'b0, 1'b1, 32'h0000_8000);
    step("seq_ffff", 1'b0, 1'b1, 32'h0000_FFFF);
    step("seq_reset", 1'b1, 1'b1, 32'h0000_FFFF);

    // Reset in the middle of loads, loading resumes right after.
    step("mid_load_a", 1'b0, 1'b1, 32'hDEAD_BEEF);
    step("mid_reset",  1'b1, 1'b1, 32'h1357_9BDF);
    step("mid_resume", 1'b0, 1'b1, 32'hCAFE_F00D);

    // Combinational select.
    check_mux("mux_s0", 32'h0000_AAAA, 32'h0000_5555, 1'b0);
    check_mux("mux_s1", 32'h0000_AAAA, 32'h0000_5555, 1'b1);
    check_mux("mux_wide", 32'hFFFF_0000, 32'h0000_FFFF, 1'b1);

    // Randomised traffic against the model.
    for (int i = 0; i < 200; i++) begin
      step("rand", ($urandom_range(7) == 0), 1'($urandom), $urandom);
      check_mux("rand_mux", $urandom, $urandom, 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flop_enable_reset.md
FLOP_ENABLE_RESET -- requirements
Module: flop_enable_reset

Interface
REQ-001 Parameter WIDTH, default 16, sets the data width of d and q in every module below.
REQ-002 clock  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  reset: synchronous, active-high; clears q to 0 on a rising clock edge.
REQ-004 enable  input  1  load enable; q captures d only when high.
REQ-005 d  input  WIDTH  data to capture.
REQ-006 q  output  WIDTH  registered state.
REQ-007 Port order SHALL be (clock, reset, enable, d, q) so that positional instantiation is supported.
REQ-008 The same deliverable SHALL contain companion module flop_reset, with parameter WIDTH (default 16) and ports in order: clock in 1, reset in 1, d in WIDTH, q out WIDTH.
REQ-009 The same deliverable SHALL contain companion module mux2, with parameter WIDTH (default 16) and ports in order: d0 in WIDTH, d1 in WIDTH, s in 1, y out WIDTH.

Function
REQ-010 flop_enable_reset SHALL update q only on the rising edge of clock.
REQ-011 At an edge with reset=1, q SHALL become all-zeros regardless of enable and d.
REQ-012 At an edge with reset=0 and enable=1, q SHALL take the value of d sampled at that edge; latency is 1 cycle.
REQ-013 At an edge with reset=0 and enable=0, q SHALL hold its previous value.
REQ-014 Changes on reset, enable or d between clock edges SHALL NOT affect q; there is no asynchronous path.
REQ-015 flop_reset SHALL behave as flop_enable_reset with enable permanently 1: q becomes 0 on an edge with reset=1, otherwise q takes d.
REQ-016 mux2 SHALL be purely combinational: y=d0 when s=0 and y=d1 when s=1, for all WIDTH bits, with no storage.
REQ-017 mux2 with s=X/Z is don't-care; synthesis SHALL produce a plain 2:1 select.
REQ-018 All values SHALL pass through unmodified, with no sign or width conversion; bit i of q or y comes from bit i of the selected input.
REQ-019 The modules SHALL be synthesizable for any WIDTH >= 1 and SHALL produce no latches.

Reset
REQ-020 The reset value of q in flop_enable_reset and flop_reset SHALL be 0 for all WIDTH bits.
REQ-021 Before the first reset edge q is unspecified; users SHALL assert reset for at least one clock edge before relying on q.
REQ-022 Reset asserted in the middle of a series of enabled loads SHALL win at that edge; loading resumes on the first edge after reset deasserts.
REQ-023 mux2 has no reset.

Verification
REQ-024 flop_enable_reset WIDTH=16: reset=1 for one edge with d=16'hBEEF and enable=1 -> q=16'h0000.
REQ-025 reset=0, enable=1, d=16'h1234 at an edge -> q=16'h1234 after that edge; then enable=0, d=16'hFFFF for 3 edges -> q stays 16'h1234.
REQ-026 reset=0, q=16'h1234; toggle d and enable between edges with no clock edge -> q unchanged; at the next edge with reset=1, enable=1, d=16'h5555 -> q=16'h0000.
REQ-027 flop_reset WIDTH=16: d sequence 16'h0001, 16'h8000, 16'hFFFF on consecutive edges -> q follows with 1-cycle lag; reset=1 on the 4th edge -> q=16'h0000.
REQ-028 mux2 default width: d0=16'hAAAA, d1=16'h5555; s=0 -> y=16'hAAAA, s=1 -> y=16'h5555, with y changing in the same delta and no clock needed.
REQ-029 WIDTH=1 and WIDTH=32 instances of all three modules pass REQ-024 to REQ-028, using the values truncated or zero-extended to the instance width.
